// File: rtl/seg_display_scheduler_pkg.sv
// Shared types and glyph constants for the 4-digit 7-segment display scheduler.
// Glyphs are active-low {dp,g,f,e,d,c,b,a}; dp is always off (bit 7 = 1).
package seg_display_scheduler_pkg;

    typedef enum logic [1:0] {
        PLAY      = 2'd0,
        BLINK_ON  = 2'd1,
        BLINK_OFF = 2'd2,
        HOLD      = 2'd3
    } state_t;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] DASH    = 8'hBF;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_N = 8'hAB;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] BLANK   = 8'hFF;

    localparam logic [3:0] AN_OFF  = 4'b1111;

    // Active-low anode pattern selecting a single digit slot.
    function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_display_scheduler_glyph_rom.sv
// Combinational BCD-to-segment lookup; non-decimal nibbles render as a dash.
module seg_glyph_rom
    import seg_display_scheduler_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] glyph
);

    // Digit decode table.
    always_comb begin
        case (bcd)
            4'd0:    glyph = GLYPH_0;
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = DASH;
        endcase
    end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexed 4-digit display driver: refresh prescaler, slot counter,
// frame-aligned score latch, leading-zero blanking and a game-over blink FSM.
module seg_display_scheduler
    import seg_display_scheduler_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned BLINK_COUNT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic        score_valid,
    input  logic        gameOver,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_start
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned BW = $clog2(BLINK_COUNT + 1);

    localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);
    localparam logic [BW-1:0] BCNT_END = BW'(BLINK_COUNT);

    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic [15:0]   score_l;
    state_t        state;
    logic [FW-1:0] fcnt;
    logic [BW-1:0] bcnt;

    logic          tick;
    logic          boundary;
    logic [1:0]    idx_n;
    logic [15:0]   score_n;
    state_t        state_n;
    logic [FW-1:0] fcnt_n;
    logic [BW-1:0] bcnt_n;
    logic [BW-1:0] bcnt_inc;
    logic [3:0]    digit;
    logic [7:0]    digit_glyph;
    logic          lz_blank;
    logic [7:0]    msg_glyph;
    logic [3:0]    disp_an;
    logic [7:0]    disp_seg;

    // Next-state values; the display below is rendered from these so that a
    // frame-boundary latch or mode change already applies to the slot-0 output.
    always_comb begin
        tick     = (pcnt == PCNT_MAX);
        boundary = tick && (idx == 2'd3);
        idx_n    = idx + 2'd1;
        score_n  = (boundary && score_valid) ? score : score_l;
        bcnt_inc = bcnt + BW'(1);
        state_n  = state;
        fcnt_n   = fcnt;
        bcnt_n   = bcnt;
        if (boundary) begin
            if (state != PLAY && !gameOver) begin
                state_n = PLAY;
                fcnt_n  = '0;
                bcnt_n  = '0;
            end else begin
                case (state)
                    PLAY: begin
                        if (gameOver) begin
                            state_n = BLINK_ON;
                            fcnt_n  = '0;
                            bcnt_n  = '0;
                        end
                    end
                    BLINK_ON: begin
                        if (fcnt == FCNT_MAX) begin
                            state_n = BLINK_OFF;
                            fcnt_n  = '0;
                        end else begin
                            fcnt_n  = fcnt + FW'(1);
                        end
                    end
                    BLINK_OFF: begin
                        if (fcnt == FCNT_MAX) begin
                            bcnt_n  = bcnt_inc;
                            fcnt_n  = '0;
                            state_n = (bcnt_inc == BCNT_END) ? HOLD : BLINK_ON;
                        end else begin
                            fcnt_n  = fcnt + FW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    seg_glyph_rom u_glyph_rom (
        .bcd   (digit),
        .glyph (digit_glyph)
    );

    // Slot content selection for the slot about to be displayed.
    always_comb begin
        digit = score_n[{idx_n, 2'b00} +: 4];
        case (idx_n)
            2'd3:    lz_blank = (score_n[15:12] == 4'h0);
            2'd2:    lz_blank = (score_n[15:8]  == 8'h00);
            2'd1:    lz_blank = (score_n[15:4]  == 12'h000);
            default: lz_blank = 1'b0;
        endcase
        case (idx_n)
            2'd3:    msg_glyph = GLYPH_E;
            2'd2:    msg_glyph = GLYPH_N;
            2'd1:    msg_glyph = GLYPH_D;
            default: msg_glyph = BLANK;
        endcase
        case (state_n)
            PLAY: begin
                disp_an  = an_for_idx(idx_n);
                disp_seg = lz_blank ? BLANK : digit_glyph;
            end
            BLINK_OFF: begin
                disp_an  = AN_OFF;
                disp_seg = BLANK;
            end
            default: begin
                disp_an  = an_for_idx(idx_n);
                disp_seg = msg_glyph;
            end
        endcase
    end

    // Prescaler, slot counter, score latch, mode FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt        <= '0;
            idx         <= '0;
            score_l     <= '0;
            state       <= PLAY;
            fcnt        <= '0;
            bcnt        <= '0;
            an          <= AN_OFF;
            seg         <= BLANK;
            frame_start <= 1'b0;
        end else begin
            pcnt        <= tick ? '0 : pcnt + PW'(1);
            frame_start <= boundary;
            if (tick) begin
                idx     <= idx_n;
                score_l <= score_n;
                state   <= state_n;
                fcnt    <= fcnt_n;
                bcnt    <= bcnt_n;
                an      <= disp_an;
                seg     <= disp_seg;
            end
        end
    end

endmodule
